// File: rtl/jk_mod_counter_pkg.sv
// Shared JK excitation codes and the per-bit excitation function for the
// JK-cell based modulo counter.
package jk_mod_counter_pkg;

  // {J,K} encodings driven into each storage cell
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // Excitation for one bit: forced transitions (wrap/load) drive J=n, K=~n;
  // incremental transitions toggle exactly the bits that change.
  function automatic logic [1:0] jk_pair(input logic q, input logic n, input logic frc);
    logic [1:0] jk;
    if (frc) begin
      jk = n ? JK_SET : JK_RST;
    end else if (q != n) begin
      jk = JK_TGL;
    end else begin
      jk = JK_HOLD;
    end
    return jk;
  endfunction

endpackage

// File: rtl/jk_mod_counter_jk_cell.sv
// One-bit JK storage cell with synchronous active-high clear.
module jk_cell
  import jk_mod_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  // Classic JK behaviour: hold, clear, set, toggle
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        JK_HOLD: q <= q;
        JK_RST:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter with parallel load. The count state lives in
// a bank of JK cells; this level computes the next value, derives per-bit J/K
// excitation, decodes terminal count and registers the wrap/load_err pulses.
module jk_mod_counter
  import jk_mod_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // MODULUS may equal 2**WIDTH, so the range check uses one extra bit.
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] nxt;
  logic             frc;
  logic             wrap_nxt;
  logic             err_nxt;
  logic [1:0]       jk [WIDTH];

  // Next-count selection with load > enable > hold priority (reset is in the cells)
  always_comb begin
    nxt      = count;
    frc      = 1'b0;
    wrap_nxt = 1'b0;
    err_nxt  = 1'b0;
    if (load) begin
      frc = 1'b1;
      if ({1'b0, load_val} < MOD_EXT) begin
        nxt = load_val;
      end else begin
        nxt     = '0;
        err_nxt = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (count == CNT_MAX) begin
          nxt      = '0;
          frc      = 1'b1;
          wrap_nxt = 1'b1;
        end else begin
          nxt = count + WIDTH'(1);
        end
      end else begin
        if (count == '0) begin
          nxt      = CNT_MAX;
          frc      = 1'b1;
          wrap_nxt = 1'b1;
        end else begin
          nxt = count - WIDTH'(1);
        end
      end
    end
  end

  // Per-bit J/K excitation feeding the storage cells
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      jk[i] = jk_pair(count[i], nxt[i], frc);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_cell u_cell (
        .clk (clk),
        .rst (rst),
        .j   (jk[gi][1]),
        .k   (jk[gi][0]),
        .q   (count[gi])
      );
    end
  endgenerate

  assign tc = en & ((up & (count == CNT_MAX)) | (~up & (count == '0)));

  // One-cycle status pulses aligned with the updated count
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= wrap_nxt;
      load_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter: a decimal (4-bit, mod 10) instance and a
// power-of-two (3-bit, mod 8) instance, checked against an arithmetic model
// through a scoreboard queue.
module tb_jk_mod_counter;

  typedef struct {
    string       tag;
    logic [31:0] count;
    logic        wrap;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=4, MODULUS=10
  logic       rst_a = 1'b0, en_a = 1'b0, up_a = 1'b0, load_a = 1'b0;
  logic [3:0] lv_a = '0;
  logic [3:0] count_a;
  logic       tc_a, wrap_a, err_a;

  // Instance B: WIDTH=3, MODULUS=8
  logic       rst_b = 1'b0, en_b = 1'b0, up_b = 1'b0, load_b = 1'b0;
  logic [2:0] lv_b = '0;
  logic [2:0] count_b;
  logic       tc_b, wrap_b, err_b;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .up(up_a), .load(load_a), .load_val(lv_a),
    .count(count_a), .tc(tc_a), .wrap(wrap_a), .load_err(err_a)
  );

  jk_mod_counter #(.WIDTH(3), .MODULUS(8)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .up(up_b), .load(load_b), .load_val(lv_b),
    .count(count_b), .tc(tc_b), .wrap(wrap_b), .load_err(err_b)
  );

  int   n_asserts = 0;
  int   n_fails   = 0;
  int   mdl_a     = 0;
  int   mdl_b     = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_asserts++;
    assert (got === want)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  // Reference behaviour: returns next count, wrap and error flags
  function automatic void model(input int m, input int cur, input bit r, input bit e,
                                input bit u, input bit l, input int lv,
                                output int nc, output bit w, output bit er);
    nc = cur; w = 1'b0; er = 1'b0;
    if (r) begin
      nc = 0;
    end else if (l) begin
      if (lv < m) nc = lv;
      else begin nc = 0; er = 1'b1; end
    end else if (e) begin
      if (u) begin
        if (cur == m - 1) begin nc = 0; w = 1'b1; end
        else nc = cur + 1;
      end else begin
        if (cur == 0) begin nc = m - 1; w = 1'b1; end
        else nc = cur - 1;
      end
    end
  endfunction

  task automatic step_a(input string tag, input bit r, input bit e, input bit u,
                        input bit l, input int lv);
    int   nc;
    bit   w, er, tcx;
    exp_t x;
    rst_a = r; en_a = e; up_a = u; load_a = l; lv_a = 4'(lv);
    #1;
    tcx = e && ((u && mdl_a == 9) || (!u && mdl_a == 0));
    check({tag, ".tc"}, 32'(tc_a), 32'(tcx));
    model(10, mdl_a, r, e, u, l, lv, nc, w, er);
    x.tag = tag; x.count = 32'(nc); x.wrap = w; x.err = er;
    sb_a.push_back(x);
    mdl_a = nc;
    @(posedge clk);
    #1;
    x = sb_a.pop_front();
    check({x.tag, ".count"}, 32'(count_a), x.count);
    check({x.tag, ".wrap"}, 32'(wrap_a), 32'(x.wrap));
    check({x.tag, ".load_err"}, 32'(err_a), 32'(x.err));
    @(negedge clk);
  endtask

  task automatic step_b(input string tag, input bit r, input bit e, input bit u);
    int   nc;
    bit   w, er, tcx;
    exp_t x;
    rst_b = r; en_b = e; up_b = u; load_b = 1'b0; lv_b = '0;
    #1;
    tcx = e && ((u && mdl_b == 7) || (!u && mdl_b == 0));
    check({tag, ".tc"}, 32'(tc_b), 32'(tcx));
    model(8, mdl_b, r, e, u, 1'b0, 0, nc, w, er);
    x.tag = tag; x.count = 32'(nc); x.wrap = w; x.err = er;
    sb_b.push_back(x);
    mdl_b = nc;
    @(posedge clk);
    #1;
    x = sb_b.pop_front();
    check({x.tag, ".count"}, 32'(count_b), x.count);
    check({x.tag, ".wrap"}, 32'(wrap_b), 32'(x.wrap));
    check({x.tag, ".load_err"}, 32'(err_b), 32'(x.err));
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);

    // Reset, then count up through the wrap
    step_a("rst_a0", 1, 0, 1, 0, 0);
    step_a("rst_a1", 1, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) step_a("up", 0, 1, 1, 0, 0);

    // Count down from 0 wraps to 9
    step_a("rst_dn", 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step_a("down", 0, 1, 0, 0, 0);

    // Loads: in range, boundary, out of range
    step_a("load7", 0, 1, 1, 1, 7);
    step_a("load12", 0, 1, 1, 1, 12);
    step_a("after_err", 0, 0, 1, 0, 0);
    step_a("load9", 0, 1, 0, 1, 9);
    step_a("load10", 0, 1, 0, 1, 10);
    step_a("load15", 0, 0, 0, 1, 15);
    step_a("idle", 0, 0, 0, 0, 0);

    // Priority: reset beats load and enable; load beats disabled count
    step_a("load5", 0, 0, 1, 1, 5);
    step_a("rst_prio", 1, 1, 1, 1, 3);
    step_a("load5b", 0, 0, 1, 1, 5);
    step_a("load_en0", 0, 0, 1, 1, 3);

    // Hold at 4, then alternate direction every cycle
    step_a("load4", 0, 0, 1, 1, 4);
    for (int i = 0; i < 3; i++) step_a("hold", 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step_a("flip", 0, 1, (i % 2) == 0, 0, 0);

    // Reset clears a pending wrap pulse
    step_a("load9b", 0, 0, 1, 1, 9);
    step_a("wrap_up", 0, 1, 1, 0, 0);
    step_a("rst_clr", 1, 1, 1, 0, 0);

    // Power-of-two instance: natural overflow/underflow are the wraps
    step_b("rst_b", 1, 0, 1);
    for (int i = 0; i < 9; i++) step_b("up8", 0, 1, 1);
    step_b("rst_b2", 1, 0, 0);
    for (int i = 0; i < 3; i++) step_b("down8", 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Synchronous modulo-N up/down counter whose state register is a bank of JK storage cells.
- Each cycle, an excitation stage computes a per-bit J/K pair from the mode inputs and the current count: 00 to hold, 11 to toggle, 10 to force 1, 01 to force 0.
- This excitation stage is the block that directly feeds the JK cells.
- Used as the timebase and sequence counter for the flip-flop exercise designs.

Parameters:
- WIDTH, 4, count width in bits.
- MODULUS, 10, count range 0..MODULUS-1; legal range 2 to 2**WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  count enable.
- up  input  1  direction: 1 counts up, 0 counts down.
- load  input  1  synchronous parallel load request.
- load_val  input  WIDTH  value to load.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational: en & ((up & count==MODULUS-1) | (~up & count==0)).
- wrap  output  1  registered one-cycle pulse in the cycle after a wrap transition.
- load_err  output  1  registered one-cycle pulse in the cycle after an out-of-range load.

Behaviour:
- Clock and reset: single clock, clk. Reset rst is synchronous and active-high.
- Reset values: count=0, wrap=0, load_err=0. tc follows the combinational equation (0 while en=0).
- Priority per rising edge: rst > load > en > hold.
- Load:
  - load_val < MODULUS: count <= load_val.
  - load_val >= MODULUS: count <= 0 and load_err=1 for one cycle.
  - Load ignores en and up. wrap stays 0 on a load cycle.
- Count up (en=1, up=1):
  - count < MODULUS-1: count+1.
  - count == MODULUS-1: count <= 0 and wrap=1 next cycle.
- Count down (en=1, up=0):
  - count > 0: count-1.
  - count == 0: count <= MODULUS-1 and wrap=1 next cycle.
- Hold (en=0, load=0): count unchanged. All cells receive J=K=0.
- Excitation rules:
  - Compute next value n.
  - Bits where n_i != q_i and the transition is a binary increment or decrement get J=K=1 (toggle).
  - On wrap or load, every bit gets J=n_i, K=~n_i (force).
  - Resulting count must equal n in every case. The JK encoding is internal and not visible at ports.
- Latency: count reflects a request one edge after it is sampled. wrap and load_err are asserted for exactly one cycle, aligned with the updated count.
- Direction change mid-count takes effect on the next edge; no dead cycle.
- Reset asserted with load or en set: reset wins; wrap and load_err are cleared the same edge.
- Arithmetic is width-exact and never produces a value >= MODULUS. When MODULUS == 2**WIDTH, natural overflow and underflow coincide with the wrap rules.

Decomposition:
- Shared package/include holds:
  - JK code constants: JK_HOLD=2'b00, JK_RST=2'b01, JK_SET=2'b10, JK_TGL=2'b11.
  - A function returning the J/K pair from (q, n, force).
- Sub-module jk_cell: one-bit JK storage with clk, rst (sync, active-high, clears to 0), j, k, q. jk_mod_counter instantiates WIDTH of them via generate.
- The top level contains excitation logic, the tc decode and the wrap/load_err registers.

Test Plan:
- Reset and count up: rst=1 for 2 cycles, then en=1, up=1 for 12 cycles → count 0,1,...,9,0,1,2. tc high while count=9. wrap high in the single cycle count=0 after 9.
- Count down from 0: after reset, en=1, up=0 → count 9,8,7. wrap pulses once in the cycle count=9. tc high at count=0 before the edge.
- Load in range and out of range, en=1:
  - load_val=7 → count=7 next cycle, no wrap.
  - load_val=12 → count=0 and load_err=1 for exactly one cycle.
- Priority:
  - Count=5 with rst=1, load=1, load_val=3, en=1 → count=0, wrap=0, load_err=0.
  - Count=5 with load=1, load_val=3, en=0 → count=3.
- Hold and direction flip:
  - Count=4, en=0 for 3 cycles → stays 4, tc=0.
  - Then en=1 with up toggled every cycle, starting up=1 → 5,4,5,4.
- Power-of-two variant: WIDTH=3, MODULUS=8, en=1, up=1 from reset for 9 cycles → 0..7,0. wrap pulses once. Bench compares count against a reference model every cycle.
